iterative_multiplier: RTL and testbench



---
 rtl/iterative_multiplier_if.sv | 13 +
 rtl/iterative_multiplier.sv | 91 +++++++++
 tb/tb_iterative_multiplier.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/iterative_multiplier_if.sv
// iterative_multiplier_if: operand request and product response handshake bundle.
interface iterative_multiplier_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, signed_a, signed_b, out_valid, out_ready;
  logic [WIDTH-1:0] input_a, input_b, output_lower, output_higher;
  modport master (
    output in_valid, input_a, input_b, signed_a, signed_b, out_ready,
    input in_ready, out_valid, output_lower, output_higher
  );
  modport slave (
    input in_valid, input_a, input_b, signed_a, signed_b, out_ready,
    output in_ready, out_valid, output_lower, output_higher
  );
endinterface

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: multi-cycle sign-magnitude shift-add multiplier retiring DIGIT bits per cycle.
module iterative_multiplier #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic flush,
  output logic busy,
  iterative_multiplier_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = $clog2(STEPS + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, lo_q, lo_d, hi_q, hi_d, mag_a, mag_b;
  logic [2*WIDTH-1:0] b_q, b_d, acc_q, acc_d, prod;
  logic neg_q, neg_d, in_ready_q, out_valid_q, busy_q, accept;
  always_comb begin
    accept = bus.in_valid & in_ready_q & ~flush;
    mag_a = (bus.signed_a & bus.input_a[WIDTH-1]) ? -bus.input_a : bus.input_a;
    mag_b = (bus.signed_b & bus.input_b[WIDTH-1]) ? -bus.input_b : bus.input_b;
    prod = neg_q ? -acc_q : acc_q;
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    neg_d = neg_q;
    lo_d = lo_q;
    hi_d = hi_q;
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: if (accept) begin
        state_d = RUN;
        a_d = mag_a;
        b_d = {{WIDTH{1'b0}}, mag_b};
        acc_d = '0;
        cnt_d = '0;
        neg_d = (bus.signed_a & bus.input_a[WIDTH-1]) ^ (bus.signed_b & bus.input_b[WIDTH-1]);
      end
      // b_q is pre-shifted each step, so it always carries the weight of the current digit
      RUN: begin
        a_d = a_q >> DIGIT;
        b_d = b_q << DIGIT;
        acc_d = acc_q + b_q * (2*WIDTH)'(a_q[DIGIT-1:0]);
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(STEPS - 1)) ? FIX : RUN;
      end
      FIX: begin
        state_d = DONE;
        lo_d = prod[WIDTH-1:0];
        hi_d = prod[2*WIDTH-1:WIDTH];
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      in_ready_q <= state_d == IDLE;
      out_valid_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.output_lower = lo_q;
  assign bus.output_higher = hi_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// tb_iterative_multiplier: drives DIGIT=1,2,4,8 instances in lockstep against an arithmetic reference.
module tb_iterative_multiplier;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n, in_valid, out_ready, flush, signed_a, signed_b;
  logic [31:0] input_a, input_b;
  logic [3:0] in_ready, out_valid, busy;
  logic [31:0] lo [4];
  logic [31:0] hi [4];
  logic [63:0] prod [4];
  int lat [4];
  int rl [4];
  int checks = 0;
  int fails = 0;

  for (genvar k = 0; k < 4; k++) begin : g
    iterative_multiplier_if #(.WIDTH(32)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.input_a = input_a;
    assign bus.input_b = input_b;
    assign bus.signed_a = signed_a;
    assign bus.signed_b = signed_b;
    assign bus.out_ready = out_ready;
    assign in_ready[k] = bus.in_ready;
    assign out_valid[k] = bus.out_valid;
    assign lo[k] = bus.output_lower;
    assign hi[k] = bus.output_higher;
    iterative_multiplier #(.WIDTH(32), .DIGIT(1 << k)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy[k]), .bus(bus)
    );
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
    longint ea, eb;
    ea = sa ? longint'(signed'(a)) : longint'(a);
    eb = sb ? longint'(signed'(b)) : longint'(b);
    return 64'(ea * eb);
  endfunction

  function automatic int exp_lat(input int k);
    return (32 >> k) + 1;
  endfunction

  // Presents one operation at a negedge, scrambles the operand inputs after the accept edge,
  // then records per instance the negedge index of out_valid and of the return to in_ready.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
    bit all;
    input_a = a; input_b = b; signed_a = sa; signed_b = sb; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin lat[k] = 0; rl[k] = 0; prod[k] = '0; end
    @(negedge clock);
    in_valid = 1'b0; input_a = $urandom; input_b = $urandom;
    signed_a = 1'($urandom); signed_b = 1'($urandom);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      all = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && lat[k] == 0) begin lat[k] = c; prod[k] = {hi[k], lo[k]}; end
        else if (in_ready[k] && lat[k] != 0 && rl[k] == 0) rl[k] = c;
        if (lat[k] == 0 || (out_ready && rl[k] == 0)) all = 1'b0;
      end
      if (all) break;
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({in_ready[k], out_valid[k], busy[k]} !== 3'b100) begin fails++; $display("FAIL reset_flags d%0d: got %b want 100", 1 << k, {in_ready[k], out_valid[k], busy[k]}); end
      checks++;
      if ({hi[k], lo[k]} !== 64'h0) begin fails++; $display("FAIL reset_outputs d%0d: got %h want 0", 1 << k, {hi[k], lo[k]}); end
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (in_ready !== 4'hF || busy !== 4'h0) begin fails++; $display("FAIL reset_release: in_ready %b busy %b want 1111 0000", in_ready, busy); end
  endtask

  task automatic test_directed(input string nm, input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb, input logic [63:0] want);
    do_op(a, b, sa, sb);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (prod[k] !== want) begin fails++; $display("FAIL %s_prod d%0d: got %h want %h", nm, 1 << k, prod[k], want); end
      checks++;
      if (lat[k] !== exp_lat(k)) begin fails++; $display("FAIL %s_latency d%0d: got %0d want %0d", nm, 1 << k, lat[k], exp_lat(k)); end
    end
  endtask

  task automatic test_back_to_back;
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rl[k] !== exp_lat(k) + 1) begin fails++; $display("FAIL b2b_ready d%0d: got %0d want %0d", 1 << k, rl[k], exp_lat(k) + 1); end
    end
    do_op(32'h00000003, 32'h00000005, 1'b0, 1'b0);
    checks++;
    if (prod[0] !== 64'd15 || lat[0] !== 33) begin fails++; $display("FAIL b2b_second: got %h/%0d want f/33", prod[0], lat[0]); end
  endtask

  task automatic test_radix;
    do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    checks++;
    if (prod[2] !== 64'h0B00EA4E_242D2080) begin fails++; $display("FAIL radix4_prod: got %h want 0b00ea4e242d2080", prod[2]); end
    checks++;
    if (lat[2] !== 9) begin fails++; $display("FAIL radix4_latency: got %0d want 9", lat[2]); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    do_op(32'h00012345, 32'h00000100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; input_a = 32'd3; input_b = 32'd3;
      @(negedge clock);
      checks++;
      if (out_valid !== 4'hF || in_ready !== 4'h0) begin fails++; $display("FAIL bp_hold_flags: out_valid %b in_ready %b want 1111 0000", out_valid, in_ready); end
      checks++;
      if ({hi[0], lo[0]} !== 64'h01234500 || {hi[3], lo[3]} !== 64'h01234500) begin fails++; $display("FAIL bp_hold_data: got %h want 1234500", {hi[0], lo[0]}); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'h0 || in_ready !== 4'hF) begin fails++; $display("FAIL bp_release: out_valid %b in_ready %b want 0000 1111", out_valid, in_ready); end
    @(negedge clock);
    checks++;
    if (busy !== 4'h0 || {hi[0], lo[0]} !== 64'h01234500) begin fails++; $display("FAIL bp_no_accept: busy %b data %h want 0000 1234500", busy, {hi[0], lo[0]}); end
  endtask

  // Aborts at RUN step 10 of the DIGIT=1 instance using flush or reset.
  task automatic test_abort(input bit use_reset);
    int seen;
    input_a = 32'h0000FFFF; input_b = 32'h00001234; signed_a = 1'b0; signed_b = 1'b0; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    checks++;
    if (busy[0] !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b want 1", busy[0]); end
    if (use_reset) reset_n = 1'b0; else flush = 1'b1;
    @(negedge clock);
    reset_n = 1'b1; flush = 1'b0;
    checks++;
    if (busy[1:0] !== 2'b00 || in_ready[1:0] !== 2'b11) begin fails++; $display("FAIL abort_idle: busy %b in_ready %b want 00 11", busy[1:0], in_ready[1:0]); end
    if (use_reset) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({hi[k], lo[k], in_ready[k], out_valid[k], busy[k]} !== {64'h0, 3'b100}) begin fails++; $display("FAIL abort_reset_state d%0d: data %h flags %b want 0 100", 1 << k, {hi[k], lo[k]}, {in_ready[k], out_valid[k], busy[k]}); end
      end
    end
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid[1:0] != 2'b00) seen++;
    end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
    test_directed("after_abort", 32'd7, 32'd6, 1'b0, 1'b0, 64'd42);
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b;
    logic sa, sb;
    logic [63:0] want;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        2: a = 32'h0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h1;
        default: b = $urandom;
      endcase
      sa = 1'($urandom); sb = 1'($urandom);
      want = ref_mul(a, b, sa, sb);
      do_op(a, b, sa, sb);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (prod[k] !== want) begin fails++; $display("FAIL rand_prod d%0d a=%h b=%h sa=%b sb=%b: got %h want %h", 1 << k, a, b, sa, sb, prod[k], want); end
        checks++;
        if (lat[k] !== exp_lat(k)) begin fails++; $display("FAIL rand_latency d%0d: got %0d want %0d", 1 << k, lat[k], exp_lat(k)); end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    input_a = '0; input_b = '0; signed_a = 1'b0; signed_b = 1'b0;
    repeat (3) @(negedge clock);
    flush = 1'b0;
    test_reset;
    test_directed("unsigned_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001);
    test_directed("signed_m1x1", 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
    test_directed("unsigned_m1x1", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 64'h00000000_FFFFFFFF);
    test_directed("most_negative", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000);
    test_directed("mulhsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF_00000001);
    test_directed("neg_zero", 32'h00000000, 32'hFFFFFFFB, 1'b1, 1'b1, 64'h0);
    test_back_to_back;
    test_radix;
    test_backpressure;
    test_abort(1'b0);
    test_abort(1'b1);
    test_random(600);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
